// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Purpose  : AXI4-Lite responder with a small word-addressed register bank.
//            Reg 0 returns a constant ID, reg 1 returns the live status word,
//            and regs 2..NUM_REGS-1 are byte-strobed read/write registers.
//            Unmapped or read-only writes, and unmapped reads, return SLVERR.
// Ports    : aclk, areset_n           clock / async active-low reset
//            aw*_i/o, w*_i/o, b*_i/o  write address / data / response
//            ar*_i/o, r*_i/o          read address / data
//            status_in_i              live status word (reg 1)
//            ctrl_regs_o              RW regs, reg k at [(k-2)*32 +: 32]
//            wr_pulse_o               one-cycle strobe per RW reg after write
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave #(
  parameter int          ADDR_W   = 32,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'h5541_5254
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  // write address channel
  input  logic [ADDR_W-1:0]            awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  // write data channel
  input  logic [31:0]                  wdata_i,
  input  logic [3:0]                   wstrb_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  // write response channel
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  // read address channel
  input  logic [ADDR_W-1:0]            araddr_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  // read data channel
  output logic [31:0]                  rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  // register bank side
  input  logic [31:0]                  status_in_i,
  output logic [(NUM_REGS-2)*32-1:0]   ctrl_regs_o,
  output logic [NUM_REGS-3:0]          wr_pulse_o
);

  localparam int          C_IDX_W  = $clog2(NUM_REGS);
  localparam int          C_NUM_RW = NUM_REGS - 2;
  localparam logic [1:0]  C_OKAY   = 2'b00;
  localparam logic [1:0]  C_SLVERR = 2'b10;

  typedef enum logic [0:0] { W_IDLE = 1'b0, W_RESP = 1'b1 } wstate_t;
  typedef enum logic [0:0] { R_IDLE = 1'b0, R_RESP = 1'b1 } rstate_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wstate_t             wstate_q, wstate_d;
  rstate_t             rstate_q, rstate_d;

  logic                aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
  logic                w_held_q,  w_held_d;
  logic [31:0]         wdata_q,   wdata_d;
  logic [3:0]          wstrb_q,   wstrb_d;
  logic [1:0]          bresp_q,   bresp_d;

  logic [31:0]         rdata_q,   rdata_d;
  logic [1:0]          rresp_q,   rresp_d;

  logic [31:0]         regs_q [C_NUM_RW];
  logic [31:0]         regs_d [C_NUM_RW];
  logic [C_NUM_RW-1:0] wr_pulse_q, wr_pulse_d;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic w_bvalid;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;

  assign w_bvalid  = (wstate_q == W_RESP);
  assign awready_o = !aw_held_q && !w_bvalid;
  assign wready_o  = !w_held_q  && !w_bvalid;
  assign arready_o = (rstate_q == R_IDLE);
  assign w_aw_hs   = awvalid_i && awready_o;
  assign w_w_hs    = wvalid_i  && wready_o;
  assign w_ar_hs   = arvalid_i && arready_o;

  // --------------------------------------------------------------------------
  // Write-side decode: the commit uses the latched beat if one is held,
  // otherwise the beat arriving on this edge.
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [31:0]        w_wr_data;
  logic [3:0]         w_wr_strb;
  logic [C_IDX_W-1:0] w_wr_idx;
  logic               w_wr_mapped;
  logic               w_wr_rw;
  logic               w_commit;

  assign w_wr_addr   = aw_held_q ? awaddr_q : awaddr_i;
  assign w_wr_data   = w_held_q  ? wdata_q  : wdata_i;
  assign w_wr_strb   = w_held_q  ? wstrb_q  : wstrb_i;
  assign w_wr_idx    = w_wr_addr[2 +: C_IDX_W];
  // any bit above the index field set means the address is outside the bank
  assign w_wr_mapped = ((w_wr_addr >> (C_IDX_W + 2)) == '0);
  assign w_wr_rw     = w_wr_mapped && (w_wr_idx >= C_IDX_W'(2));

  // --------------------------------------------------------------------------
  // Write FSM: next state and latch control
  // --------------------------------------------------------------------------
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (w_aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr_i;
        end
        if (w_w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata_i;
          wstrb_d  = wstrb_i;
        end
        if ((aw_held_q || w_aw_hs) && (w_held_q || w_w_hs)) begin
          w_commit  = 1'b1;
          wstate_d  = W_RESP;
          bresp_d   = w_wr_rw ? C_OKAY : C_SLVERR;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          wstate_d  = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register bank update and write strobes
  // --------------------------------------------------------------------------
  always_comb begin
    wr_pulse_d = '0;
    for (int k = 0; k < C_NUM_RW; k++) begin
      regs_d[k] = regs_q[k];
      if (w_commit && w_wr_rw && (w_wr_idx == C_IDX_W'(k + 2))) begin
        wr_pulse_d[k] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (w_wr_strb[b]) begin
            regs_d[k][8*b +: 8] = w_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: the response is captured on the AR edge, so a read racing a
  // write to the same register sees the value from before that write.
  // --------------------------------------------------------------------------
  logic [C_IDX_W-1:0] w_rd_idx;
  logic               w_rd_mapped;
  logic [31:0]        w_rd_word;

  assign w_rd_idx    = araddr_i[2 +: C_IDX_W];
  assign w_rd_mapped = ((araddr_i >> (C_IDX_W + 2)) == '0);

  always_comb begin
    w_rd_word = '0;
    if (w_rd_idx == C_IDX_W'(0)) begin
      w_rd_word = ID_VALUE;
    end else if (w_rd_idx == C_IDX_W'(1)) begin
      w_rd_word = status_in_i;
    end else begin
      for (int k = 0; k < C_NUM_RW; k++) begin
        if (w_rd_idx == C_IDX_W'(k + 2)) begin
          w_rd_word = regs_q[k];
        end
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (w_ar_hs) begin
          rstate_d = R_RESP;
          rdata_d  = w_rd_mapped ? w_rd_word : 32'h0;
          rresp_d  = w_rd_mapped ? C_OKAY : C_SLVERR;
        end
      end
      R_RESP: begin
        if (rready_i) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= C_OKAY;
      rdata_q    <= '0;
      rresp_q    <= C_OKAY;
      wr_pulse_q <= '0;
      for (int k = 0; k < C_NUM_RW; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int k = 0; k < C_NUM_RW; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bvalid_o   = w_bvalid;
  assign bresp_o    = bresp_q;
  assign rvalid_o   = (rstate_q == R_RESP);
  assign rdata_o    = rdata_q;
  assign rresp_o    = rresp_q;
  assign wr_pulse_o = wr_pulse_q;

  for (genvar k = 0; k < C_NUM_RW; k++) begin : g_flat
    assign ctrl_regs_o[k*32 +: 32] = regs_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_slave
// Purpose  : Directed self-checking bench for axi_lite_reg_slave.
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_slave;

  localparam int C_NRW = 6;

  logic                  aclk;
  logic                  areset_n;
  logic [31:0]           awaddr_i;
  logic                  awvalid_i;
  logic                  awready_o;
  logic [31:0]           wdata_i;
  logic [3:0]            wstrb_i;
  logic                  wvalid_i;
  logic                  wready_o;
  logic [1:0]            bresp_o;
  logic                  bvalid_o;
  logic                  bready_i;
  logic [31:0]           araddr_i;
  logic                  arvalid_i;
  logic                  arready_o;
  logic [31:0]           rdata_o;
  logic [1:0]            rresp_o;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [31:0]           status_in_i;
  logic [C_NRW*32-1:0]   ctrl_regs_o;
  logic [C_NRW-1:0]      wr_pulse_o;

  int vectors;
  int miscompares;

  axi_lite_reg_slave #(
    .ADDR_W   (32),
    .NUM_REGS (8),
    .ID_VALUE (32'h5541_5254)
  ) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .awaddr_i    (awaddr_i),
    .awvalid_i   (awvalid_i),
    .awready_o   (awready_o),
    .wdata_i     (wdata_i),
    .wstrb_i     (wstrb_i),
    .wvalid_i    (wvalid_i),
    .wready_o    (wready_o),
    .bresp_o     (bresp_o),
    .bvalid_o    (bvalid_o),
    .bready_i    (bready_i),
    .araddr_i    (araddr_i),
    .arvalid_i   (arvalid_i),
    .arready_o   (arready_o),
    .rdata_o     (rdata_o),
    .rresp_o     (rresp_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .status_in_i (status_in_i),
    .ctrl_regs_o (ctrl_regs_o),
    .wr_pulse_o  (wr_pulse_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // --------------------------------------------------------------------------
  // Bus drivers (stimulus only; checking is done in the test tasks)
  // --------------------------------------------------------------------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_d, input int w_d,
                          output logic [1:0] resp, output logic bv_now,
                          output logic [C_NRW-1:0] pulse_now,
                          output logic [C_NRW-1:0] pulse_next,
                          output logic bv_next, output logic blocked,
                          output logic timeout);
    int t;
    logic aw_done, w_done, aw_fire, w_fire;
    t = 0; aw_done = 1'b0; w_done = 1'b0; blocked = 1'b1; timeout = 1'b0;
    bready_i = 1'b1;
    while (!(aw_done && w_done) && t < 40) begin
      if (t == aw_d) begin awvalid_i = 1'b1; awaddr_i = addr; end
      if (t == w_d)  begin wvalid_i = 1'b1; wdata_i = data; wstrb_i = strb; end
      if (aw_done && awready_o) blocked = 1'b0;
      if (w_done && wready_o)   blocked = 1'b0;
      aw_fire = awvalid_i && awready_o;
      w_fire  = wvalid_i && wready_o;
      @(negedge aclk);
      t++;
      if (aw_fire) begin awvalid_i = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid_i = 1'b0; w_done = 1'b1; end
    end
    timeout    = !(aw_done && w_done);
    bv_now     = bvalid_o;
    resp       = bresp_o;
    pulse_now  = wr_pulse_o;
    @(negedge aclk);
    bv_next    = bvalid_o;
    pulse_next = wr_pulse_o;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    araddr_i = addr; arvalid_i = 1'b1; rready_i = 1'b1; lat = 0;
    @(negedge aclk);
    lat = 1;
    arvalid_i = 1'b0;
    while (!rvalid_o && lat < 20) begin
      @(negedge aclk);
      lat++;
    end
    data = rdata_o;
    resp = rresp_o;
    @(negedge aclk);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    vectors++;
    if (bvalid_o !== 1'b0 || rvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_valid: bvalid=%b rvalid=%b required 0 0", bvalid_o, rvalid_o);
    end
    areset_n = 1'b1;
    @(negedge aclk);
    vectors++;
    if ({awready_o, wready_o, arready_o} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_readies: aw/w/ar=%b required 111", {awready_o, wready_o, arready_o});
    end
    vectors++;
    if ({bvalid_o, rvalid_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valids: b/r=%b required 00", {bvalid_o, rvalid_o});
    end
    vectors++;
    if (ctrl_regs_o !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl_regs: got %h required 0", ctrl_regs_o);
    end
    vectors++;
    if (wr_pulse_o !== '0 || rdata_o !== 32'h0 || bresp_o !== 2'b00 || rresp_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs: pulse=%b rdata=%h bresp=%b rresp=%b required all 0",
               wr_pulse_o, rdata_o, bresp_o, rresp_o);
    end
  endtask

  task automatic test_read_id_status();
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(32'h0, d, r, lat);
    vectors++;
    if (d !== 32'h5541_5254 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL read_id: rdata=%h rresp=%b required 55415254 00", d, r);
    end
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL read_latency: got %0d cycles required 1", lat);
    end
    status_in_i = 32'h0000_00A5;
    do_read(32'h4, d, r, lat);
    vectors++;
    if (d !== 32'h0000_00A5 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL read_status: rdata=%h rresp=%b required 000000a5 00", d, r);
    end
  endtask

  task automatic test_write_order();
    logic [1:0] resp; logic bvn, bvx, blk, to; logic [C_NRW-1:0] pn, px;
    logic [31:0] d; logic [1:0] r; int lat;
    // W first, AW three cycles later
    do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (to || resp !== 2'b00 || bvn !== 1'b1 || bvx !== 1'b0) begin
      miscompares++;
      $display("FAIL wfirst_resp: to=%b bresp=%b bvalid=%b/%b required 0 00 1/0", to, resp, bvn, bvx);
    end
    vectors++;
    if (pn !== 6'b000001 || px !== 6'b000000) begin
      miscompares++;
      $display("FAIL wfirst_pulse: pulse=%b then %b required 000001 then 000000", pn, px);
    end
    vectors++;
    if (blk !== 1'b1) begin
      miscompares++;
      $display("FAIL wfirst_wready_blocked: got %b required 1", blk);
    end
    vectors++;
    if (ctrl_regs_o[0 +: 32] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wfirst_reg2: got %h required deadbeef", ctrl_regs_o[0 +: 32]);
    end
    // AW first, W two cycles later
    do_write(32'hC, 32'h1234_5678, 4'hF, 0, 2, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (to || resp !== 2'b00 || bvn !== 1'b1 || pn !== 6'b000010 || blk !== 1'b1) begin
      miscompares++;
      $display("FAIL awfirst_resp: to=%b bresp=%b bvalid=%b pulse=%b blocked=%b required 0 00 1 000010 1",
               to, resp, bvn, pn, blk);
    end
    vectors++;
    if (ctrl_regs_o[32 +: 32] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL awfirst_reg3: got %h required 12345678", ctrl_regs_o[32 +: 32]);
    end
    // AW and W together, top register
    do_write(32'h1C, 32'h0FF0_55AA, 4'hF, 0, 0, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (to || resp !== 2'b00 || bvn !== 1'b1 || pn !== 6'b100000 || px !== 6'b0) begin
      miscompares++;
      $display("FAIL together_resp: to=%b bresp=%b bvalid=%b pulse=%b/%b required 0 00 1 100000/000000",
               to, resp, bvn, pn, px);
    end
    vectors++;
    if (ctrl_regs_o[160 +: 32] !== 32'h0FF0_55AA) begin
      miscompares++;
      $display("FAIL together_reg7: got %h required 0ff055aa", ctrl_regs_o[160 +: 32]);
    end
    do_read(32'h8, d, r, lat);
    vectors++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      miscompares++;
      $display("FAIL readback_reg2: rdata=%h rresp=%b required deadbeef 00", d, r);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic bvn, bvx, blk, to; logic [C_NRW-1:0] pn, px;
    do_write(32'h8, 32'h1122_3344, 4'b0101, 0, 0, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (ctrl_regs_o[0 +: 32] !== 32'hDE22_BE44 || resp !== 2'b00) begin
      miscompares++;
      $display("FAIL strobe_reg2: got %h bresp=%b required de22be44 00", ctrl_regs_o[0 +: 32], resp);
    end
    do_write(32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (resp !== 2'b00 || pn !== 6'b000100 || ctrl_regs_o[64 +: 32] !== 32'h0) begin
      miscompares++;
      $display("FAIL strobe_zero: bresp=%b pulse=%b reg4=%h required 00 000100 00000000",
               resp, pn, ctrl_regs_o[64 +: 32]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic bvn, bvx, blk, to; logic [C_NRW-1:0] pn, px;
    logic [31:0] d; logic [1:0] r; int lat;
    logic [C_NRW*32-1:0] exp_regs;
    exp_regs = {32'h0FF0_55AA, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'hDE22_BE44};
    do_write(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (resp !== 2'b10 || bvn !== 1'b1 || pn !== 6'b0 || ctrl_regs_o !== exp_regs) begin
      miscompares++;
      $display("FAIL write_ro: bresp=%b bvalid=%b pulse=%b regs=%h required 10 1 000000 %h",
               resp, bvn, pn, ctrl_regs_o, exp_regs);
    end
    do_write(32'h108, 32'hFFFF_FFFF, 4'hF, 1, 0, resp, bvn, pn, px, bvx, blk, to);
    vectors++;
    if (resp !== 2'b10 || pn !== 6'b0 || ctrl_regs_o !== exp_regs) begin
      miscompares++;
      $display("FAIL write_unmapped: bresp=%b pulse=%b regs=%h required 10 000000 %h",
               resp, pn, ctrl_regs_o, exp_regs);
    end
    do_read(32'h100, d, r, lat);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin
      miscompares++;
      $display("FAIL read_unmapped: rdata=%h rresp=%b required 00000000 10", d, r);
    end
    // low two address bits are ignored
    do_read(32'hB, d, r, lat);
    vectors++;
    if (d !== 32'hDE22_BE44 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL read_unaligned: rdata=%h rresp=%b required de22be44 00", d, r);
    end
  endtask

  task automatic test_same_cycle();
    awaddr_i = 32'hC; wdata_i = 32'hCAFE_F00D; wstrb_i = 4'hF;
    araddr_i = 32'hC; awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1;
    bready_i = 1'b1; rready_i = 1'b1;
    @(negedge aclk);
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    vectors++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL same_cycle_read: rvalid=%b rdata=%h required 1 12345678", rvalid_o, rdata_o);
    end
    vectors++;
    if (bvalid_o !== 1'b1 || ctrl_regs_o[32 +: 32] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL same_cycle_write: bvalid=%b reg3=%h required 1 cafef00d",
               bvalid_o, ctrl_regs_o[32 +: 32]);
    end
    @(negedge aclk);
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; logic [1:0] b0, r0;
    bready_i = 1'b0; rready_i = 1'b0;
    awaddr_i = 32'h14; wdata_i = 32'hA5A5_5A5A; wstrb_i = 4'hF; araddr_i = 32'h8;
    awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1;
    @(negedge aclk);
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    d0 = rdata_o; b0 = bresp_o; r0 = rresp_o;
    vectors++;
    if (d0 !== 32'hDE22_BE44 || b0 !== 2'b00 || r0 !== 2'b00 || ctrl_regs_o[96 +: 32] !== 32'hA5A5_5A5A) begin
      miscompares++;
      $display("FAIL bp_first: rdata=%h bresp=%b rresp=%b reg5=%h required de22be44 00 00 a5a55a5a",
               d0, b0, r0, ctrl_regs_o[96 +: 32]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      vectors++;
      if (bvalid_o !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'hDE22_BE44 ||
          bresp_o !== 2'b00 || rresp_o !== 2'b00 || {awready_o, wready_o, arready_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: b/r valid=%b%b rdata=%h bresp=%b rresp=%b readies=%b required 11 de22be44 00 00 000",
                 i, bvalid_o, rvalid_o, rdata_o, bresp_o, rresp_o, {awready_o, wready_o, arready_o});
      end
    end
    // reset dropped in mid-response, away from any clock edge
    #2 areset_n = 1'b0;
    #1;
    vectors++;
    if (bvalid_o !== 1'b0 || rvalid_o !== 1'b0 || ctrl_regs_o !== '0 || wr_pulse_o !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: bvalid=%b rvalid=%b regs=%h pulse=%b required 0 0 0 0",
               bvalid_o, rvalid_o, ctrl_regs_o, wr_pulse_o);
    end
    @(negedge aclk);
    areset_n = 1'b1;
    bready_i = 1'b1; rready_i = 1'b1;
    @(negedge aclk);
    vectors++;
    if ({awready_o, wready_o, arready_o} !== 3'b111 || bvalid_o !== 1'b0 || rvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: readies=%b b/r=%b%b required 111 00",
               {awready_o, wready_o, arready_o}, bvalid_o, rvalid_o);
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  initial begin
    vectors = 0; miscompares = 0;
    areset_n = 1'b0;
    awaddr_i = '0; awvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
    bready_i = 1'b1; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b1;
    status_in_i = 32'h0;
    test_reset();
    test_read_id_status();
    test_write_order();
    test_strobe();
    test_errors();
    test_same_cycle();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of tests");
    $fatal(1);
  end

endmodule
`default_nettype wire
